accum_row_fifo: RTL and testbench
=================================

Name: accum_row_fifo

Overview:
- Multi-lane row FIFO between the systolic array output and the writeback path of the accumulator controller.
- Each entry is a row of LANES signed partial sums. A new row can be pushed, or a partial sum can be added into the most recently pushed row (tail accumulate).
- First-word-fall-through read. A programmable number of initial read requests after reset or flush is swallowed (start-up skip).
- Adds occupancy count, almost-full flag, soft flush and saturation control.

Parameters:
- DEPTH, 8, number of row entries; must be a power of two and at least 2.
- LANES, 4, lanes per row.
- DWIDTH, 16, signed width of each lane.
- SKIP_RD, 1, number of rd_en cycles swallowed after rst/clr; 0 disables the skip.
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL.
- SAT, 1, accumulate mode: 1 = saturate to the signed DWIDTH range, 0 = wrap.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- clr, in, 1, synchronous flush: pointers, count and skip counter return to their reset values; memory contents are kept.
- wr_en, in, 1, write request.
- wr_acc, in, 1, qualifies wr_en: 0 = push a new row, 1 = add din into the tail row.
- din, in, LANES*DWIDTH, row data; lane i is din[i*DWIDTH +: DWIDTH].
- rd_en, in, 1, pop request.
- dout, out, LANES*DWIDTH, head row, combinational from memory at rptr.
- empty, out, 1, count==0.
- full, out, 1, count==DEPTH.
- almost_full, out, 1, count>=AF_LVL.
- count, out, $clog2(DEPTH)+1, number of occupied entries.
- skip_busy, out, 1, high while the skip counter is below SKIP_RD.
- acc_err, out, 1, one-cycle pulse when an accumulate is dropped.

Behaviour:
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits, using the MSB wrap scheme. Memory index = low bits. count = wptr - rptr.
- Reset (rst=1): wptr=rptr=0 and skip counter=0; all memory entries are zeroed. After reset: dout=0, empty=1, full=0, almost_full=0 (assuming AF_LVL>0), count=0, skip_busy=(SKIP_RD>0), acc_err=0.
- rst has priority over clr. clr has priority over all same-cycle rd/wr.
- Skip phase, while skip_busy=1:
  - each rd_en cycle increments the skip counter; no pop occurs.
  - the counter advances whether or not the FIFO is empty.
  - skip_busy drops the cycle after the SKIP_RD-th rd_en.
- Effective pop: pop = rd_en & !skip_busy & !empty.
  - On pop, rptr advances at the clock edge.
  - dout reflects the new head in the same cycle as the rptr update (zero added latency).
- Push (wr_en & !wr_acc):
  - accepted iff !full, or if a pop happens in the same cycle (full & pop allows the push).
  - writes din to mem[wptr]; wptr advances.
  - a push on a full FIFO with no pop is dropped silently; no state changes.
- Accumulate (wr_en & wr_acc):
  - target is mem[wptr-1]. Each lane gets mem_lane + din_lane as a signed add, computed in DWIDTH+1 bits.
  - if SAT=1, the result clamps to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; if SAT=0, the result is truncated.
  - pointers and count are unchanged.
  - if empty: treated as a push of din; acc_err=0.
  - if count==1 and a pop happens the same cycle (the tail is being popped): the accumulate is dropped and acc_err pulses. The popped dout shows the pre-accumulate value.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full/empty are derived only from the pointers; no registered flags.
- count, full, empty and almost_full update on the clock edge after the causing event.
- Wrap-around: the index wraps modulo DEPTH and the MSB toggles. full = (MSBs differ) & (index equal).

Decomposition:
- Shared package Config gets:
  - localparam-style function sat_add(a, b, width, sat).
  - typedef lane_t (signed DWIDTH).
  - typedef row_t (LANES x lane_t).
- One sub-module, rd_skip_ctrl: the skip counter/FSM with states SKIP and RUN.
  - SKIP goes to RUN when the counter reaches SKIP_RD.
  - RUN goes to SKIP on clr or rst.
  - it outputs skip_busy and rd_gated.
  - every state defines every output, so no latches.
- Storage, pointers, count and accumulate datapath stay in the top module.

Test Plan (DEPTH=4, LANES=2, DWIDTH=8, SKIP_RD=1, SAT=1 unless stated):
- Reset then rd_en 1 cycle -> no pop, skip_busy 1→0. Push rows {1,2},{3,4}, count=2; rd_en 2 cycles -> dout {1,2} then {3,4}; empty=1 afterwards.
- Push 4 rows -> full=1, almost_full=1 from count=2. A fifth push without pop is dropped, count=4. Push with pop on full -> count stays 4 and the new row lands at the wrapped index 0.
- Push {100,-100}, then accumulate {50,-50} -> dout {127,-128} with SAT=1. Same stimulus with SAT=0 -> {-106,106}.
- Accumulate on empty with {5,6} -> behaves as push, count=1. Then accumulate {1,1} + rd_en the same cycle -> dout {5,6} popped, acc_err pulses, count=0.
- Fill 3 rows, assert clr mid-stream together with wr_en -> count=0, empty=1, skip_busy=1; the write is ignored. The next rd_en is swallowed.
- 200-cycle random push/pop/accumulate run against a scoreboard model -> dout/count match on every cycle; no X on outputs after reset.

Source files
------------

// File: rtl/accum_row_fifo_pkg.sv
// Shared types and the lane arithmetic helper for the accumulator row FIFO.
package accum_row_fifo_pkg;

    localparam int unsigned MAX_W      = 64;
    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned LANES_DEF  = 4;

    typedef logic signed [DWIDTH_DEF-1:0] lane_t;
    typedef lane_t [LANES_DEF-1:0]        row_t;
    typedef logic signed [MAX_W-1:0]      wide_t;

    typedef enum logic [0:0] {StSkip, StRun} skip_st_e;

    // Operands arrive sign-extended to MAX_W, so the raw sum cannot overflow.
    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input int unsigned width, input bit sat);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        wide_t res;
        sum = a + b;
        hi  = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (width - 1));
        res = (sum <<< (MAX_W - width)) >>> (MAX_W - width);
        if (sat) begin
            if (sum > hi) begin
                res = hi;
            end else if (sum < lo) begin
                res = lo;
            end else begin
                res = sum;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/accum_row_fifo_rd_skip_ctrl.sv
// Swallows the first SKIP_RD read requests after reset or flush.
module accum_row_fifo_rd_skip_ctrl
    import accum_row_fifo_pkg::*;
#(
    parameter int unsigned SKIP_RD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic rd_en,
    output logic skip_busy,
    output logic rd_gated
);

    localparam int unsigned CW = (SKIP_RD > 1) ? $clog2(SKIP_RD) : 1;
    localparam logic [CW-1:0] LAST = CW'((SKIP_RD > 0) ? SKIP_RD - 1 : 0);
    localparam skip_st_e INIT = (SKIP_RD > 0) ? StSkip : StRun;

    skip_st_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        skip_busy = 1'b0;
        rd_gated  = 1'b0;
        unique case (state_q)
            StSkip: begin
                skip_busy = 1'b1;
                if (rd_en) begin
                    if (cnt_q == LAST) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StRun: begin
                rd_gated = rd_en;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        if (clr) begin
            state_d = INIT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/accum_row_fifo.sv
// Multi-lane row FIFO with tail accumulate, first-word-fall-through read and start-up skip.
module accum_row_fifo
    import accum_row_fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned SKIP_RD = 1,
    parameter int unsigned AF_LVL  = DEPTH - 2,
    parameter int unsigned SAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic                          wr_acc,
    input  logic [LANES*DWIDTH-1:0]       din,
    input  logic                          rd_en,
    output logic [LANES*DWIDTH-1:0]       dout,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          skip_busy,
    output logic                          acc_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RW = LANES * DWIDTH;

    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          acc_err_q, acc_err_d;

    logic [AW-1:0] widx, ridx, tidx;
    logic          rd_gated, pop, wr_push, wr_accum, push_ok, acc_drop, acc_ok;
    logic [RW-1:0] acc_row;
    logic signed [DWIDTH-1:0] lane_a, lane_b;
    wide_t         lane_s;

    accum_row_fifo_rd_skip_ctrl #(
        .SKIP_RD(SKIP_RD)
    ) u_skip (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rd_en    (rd_en),
        .skip_busy(skip_busy),
        .rd_gated (rd_gated)
    );

    assign widx        = wptr_q[AW-1:0];
    assign ridx        = rptr_q[AW-1:0];
    assign tidx        = widx - AW'(1);
    assign count       = wptr_q - rptr_q;
    assign empty       = (wptr_q == rptr_q);
    assign full        = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
    assign almost_full = (count >= PW'(AF_LVL));
    assign dout        = mem_q[ridx];
    assign acc_err     = acc_err_q;

    // An accumulate into an empty FIFO degrades to a push of din.
    assign pop      = rd_gated & ~empty;
    assign wr_push  = wr_en & (~wr_acc | empty);
    assign wr_accum = wr_en & wr_acc & ~empty;
    assign push_ok  = wr_push & (~full | pop);
    assign acc_drop = wr_accum & (count == PW'(1)) & pop;
    assign acc_ok   = wr_accum & ~acc_drop;

    always_comb begin
        acc_row = '0;
        lane_a  = '0;
        lane_b  = '0;
        lane_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = mem_q[tidx][i*DWIDTH +: DWIDTH];
            lane_b = din[i*DWIDTH +: DWIDTH];
            lane_s = sat_add(wide_t'(lane_a), wide_t'(lane_b), DWIDTH, SAT != 0);
            acc_row[i*DWIDTH +: DWIDTH] = lane_s[DWIDTH-1:0];
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_d     = mem_q;
        acc_err_d = 1'b0;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (push_ok) begin
                mem_d[widx] = din;
                wptr_d      = wptr_q + PW'(1);
            end else if (acc_ok) begin
                mem_d[tidx] = acc_row;
            end
            acc_err_d = acc_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            acc_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            acc_err_q <= acc_err_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_accum_row_fifo.sv
// Scoreboard bench for accum_row_fifo: queue-based reference model plus directed checks.
module tb_accum_row_fifo;

    localparam int DEPTH   = 4;
    localparam int LANES   = 2;
    localparam int DWIDTH  = 8;
    localparam int SKIP_RD = 1;
    localparam int AF_LVL  = 2;
    localparam int RW      = LANES * DWIDTH;

    logic          clk = 1'b0;
    logic          rst, clr, wr_en, wr_acc, rd_en;
    logic [RW-1:0] din;
    logic [RW-1:0] dout, dout_w;
    logic          empty, full, almost_full, skip_busy, acc_err;
    logic          empty_w, full_w, almost_full_w, skip_busy_w, acc_err_w;
    logic [2:0]    count, count_w;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [RW-1:0] dout;
        bit            dv;
        int            cnt;
        bit            e, f, af, sb, ae;
    } snap_t;

    logic [RW-1:0] mq[$];
    snap_t         exp_q[$];
    int            skip_left;
    bit            m_acc_err;

    accum_row_fifo #(
        .DEPTH(DEPTH), .LANES(LANES), .DWIDTH(DWIDTH), .SKIP_RD(SKIP_RD), .AF_LVL(AF_LVL), .SAT(1)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_acc(wr_acc), .din(din),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .almost_full(almost_full),
        .count(count), .skip_busy(skip_busy), .acc_err(acc_err)
    );

    accum_row_fifo #(
        .DEPTH(DEPTH), .LANES(LANES), .DWIDTH(DWIDTH), .SKIP_RD(SKIP_RD), .AF_LVL(AF_LVL), .SAT(0)
    ) dut_w (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_acc(wr_acc), .din(din),
        .rd_en(rd_en), .dout(dout_w), .empty(empty_w), .full(full_w),
        .almost_full(almost_full_w), .count(count_w), .skip_busy(skip_busy_w),
        .acc_err(acc_err_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_add(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        skip_left = SKIP_RD;
        m_acc_err = 1'b0;
    endtask

    // Drives one cycle, records the state expected during it, then advances the model.
    task automatic tick(input bit we, input bit wa, input bit rd, input bit cl,
                        input logic [RW-1:0] d);
        snap_t         s;
        bit            busy, pop;
        int            n;
        logic [RW-1:0] t;
        wr_en = we; wr_acc = wa; rd_en = rd; clr = cl; din = d;
        n      = mq.size();
        s.dv   = (n > 0);
        s.dout = (n > 0) ? mq[0] : '0;
        s.cnt  = n;
        s.e    = (n == 0);
        s.f    = (n == DEPTH);
        s.af   = (n >= AF_LVL);
        s.sb   = (skip_left > 0);
        s.ae   = m_acc_err;
        exp_q.push_back(s);
        m_acc_err = 1'b0;
        if (cl) begin
            mq.delete();
            skip_left = SKIP_RD;
        end else begin
            busy = (skip_left > 0);
            if (rd && busy) skip_left--;
            pop = rd && !busy && (n > 0);
            if (we && wa && n > 0) begin
                if (n == 1 && pop) begin
                    m_acc_err = 1'b1;
                end else begin
                    t = mq[n-1];
                    mq[n-1] = {lane_add(t[15:8], d[15:8]), lane_add(t[7:0], d[7:0])};
                end
            end
            if (pop) void'(mq.pop_front());
            if (we && (!wa || n == 0) && (n < DEPTH || pop)) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_acc = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        snap_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_count", 32'(count), 32'(e.cnt));
            chk("mon_empty", 32'(empty), 32'(e.e));
            chk("mon_full", 32'(full), 32'(e.f));
            chk("mon_almost_full", 32'(almost_full), 32'(e.af));
            chk("mon_skip_busy", 32'(skip_busy), 32'(e.sb));
            chk("mon_acc_err", 32'(acc_err), 32'(e.ae));
            if (e.dv) chk("mon_dout", 32'(dout), 32'(e.dout));
            chk("mon_no_x", 32'($isunknown({dout, count, empty, full, almost_full,
                                            skip_busy, acc_err})), 32'(0));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit we, wa, rd, cl;
        do_reset();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_skip_busy", 32'(skip_busy), 1);
        chk("rst_acc_err", 32'(acc_err), 0);
        chk("rst_dout", 32'(dout), 0);

        // Start-up skip then basic FWFT ordering.
        tick(0, 0, 1, 0, '0);
        chk("skip_done", 32'(skip_busy), 0);
        chk("skip_no_pop", 32'(empty), 1);
        tick(1, 0, 0, 0, 16'h0201);
        tick(1, 0, 0, 0, 16'h0403);
        chk("two_count", 32'(count), 2);
        chk("head_first", 32'(dout), 32'h0201);
        tick(0, 0, 1, 0, '0);
        chk("head_second", 32'(dout), 32'h0403);
        tick(0, 0, 1, 0, '0);
        chk("drained_empty", 32'(empty), 1);

        // Full, dropped push, push with pop at the wrap point.
        do_reset();
        tick(0, 0, 1, 0, '0);
        tick(1, 0, 0, 0, 16'h0B0A);
        chk("af_at_1", 32'(almost_full), 0);
        tick(1, 0, 0, 0, 16'h1514);
        chk("af_at_2", 32'(almost_full), 1);
        tick(1, 0, 0, 0, 16'h1F1E);
        tick(1, 0, 0, 0, 16'h2928);
        chk("full_at_4", 32'(full), 1);
        tick(1, 0, 0, 0, 16'h3332);
        chk("drop_count", 32'(count), 4);
        chk("drop_head", 32'(dout), 32'h0B0A);
        tick(1, 0, 1, 0, 16'h3D3C);
        chk("pushpop_count", 32'(count), 4);
        chk("pushpop_head", 32'(dout), 32'h1514);
        repeat (3) tick(0, 0, 1, 0, '0);
        chk("wrapped_row", 32'(dout), 32'h3D3C);
        tick(0, 0, 1, 0, '0);

        // Saturating vs wrapping accumulate.
        do_reset();
        tick(0, 0, 1, 0, '0);
        tick(1, 0, 0, 0, 16'h9C64);
        tick(1, 1, 0, 0, 16'hCE32);
        chk("sat1_dout", 32'(dout), 32'h807F);
        chk("sat0_dout", 32'(dout_w), 32'h6A96);
        chk("acc_count", 32'(count), 1);

        // Accumulate on empty, then accumulate racing a pop of the only row.
        do_reset();
        tick(0, 0, 1, 0, '0);
        tick(1, 1, 0, 0, 16'h0605);
        chk("acc_empty_count", 32'(count), 1);
        chk("acc_empty_dout", 32'(dout), 32'h0605);
        tick(1, 1, 1, 0, 16'h0101);
        chk("acc_drop_count", 32'(count), 0);
        chk("acc_err_pulse", 32'(acc_err), 1);
        tick(0, 0, 0, 0, '0);
        chk("acc_err_clear", 32'(acc_err), 0);

        // Flush mid-stream with a write in the same cycle.
        repeat (3) tick(1, 0, 0, 0, 16'h1111);
        tick(1, 0, 0, 1, 16'h2222);
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_skip_busy", 32'(skip_busy), 1);
        tick(1, 0, 0, 0, 16'h7777);
        tick(0, 0, 1, 0, '0);
        chk("clr_rd_swallowed", 32'(count), 1);
        tick(0, 0, 1, 0, '0);
        chk("clr_then_pop", 32'(count), 0);

        // Random mix against the model.
        for (int i = 0; i < 200; i++) begin
            we = ($urandom_range(0, 99) < 60);
            wa = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 99) < 45);
            cl = ($urandom_range(0, 63) == 0);
            tick(we, wa, rd, cl, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
